// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of a single-ported data
// memory. It performs byte, halfword and word loads and stores, with lane
// replication on stores and sign or zero extension on loads. Misaligned
// accesses and the illegal size code are reported back and never reach memory.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   pN_req..pN_wdata  requester N command (N = 0, 1); req is held until pN_ack
//   pN_ack/err/rdata  one-cycle completion pulse, error flag, load result
//   daddr/dwdata/we/ce  memory command, driven only in the ACCESS state
//   drdata            combinational memory read data
module dmem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_wr,
  input  logic [1:0]  p0_size,
  input  logic        p0_uns,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_wr,
  input  logic [1:0]  p1_size,
  input  logic        p1_uns,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  we,
  output logic        ce,
  input  logic [31:0] drdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t      state;
  logic        last;      // last granted port, 1 = port1
  logic        gnt;       // port owning the current access
  logic        l_wr, l_uns;
  logic [1:0]  l_size;
  logic [31:0] l_addr, l_wdata;

  logic        any_req, sel, illegal;
  logic [7:0]  rd_b;
  logic [15:0] rd_h;
  logic [31:0] load_val;

  assign any_req = p0_req | p1_req;
  // On a tie the port not granted last wins; otherwise the only requester wins.
  assign sel = (p0_req & p1_req) ? ~last : p1_req;

  always_comb begin
    illegal = 1'b0;
    case (l_size)
      2'b01:   illegal = l_addr[0];
      2'b10:   illegal = |l_addr[1:0];
      2'b11:   illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
  end

  // Memory command is a pure decode of the registered state. An async reset
  // therefore drops ce/we at once, without waiting for a clock edge.
  always_comb begin
    ce     = 1'b0;
    we     = 4'b0000;
    daddr  = '0;
    dwdata = '0;
    if (state == ACCESS && !illegal) begin
      ce    = 1'b1;
      daddr = {l_addr[31:2], 2'b00};
      case (l_size)
        2'b00: begin
          dwdata = {4{l_wdata[7:0]}};
          we     = 4'b0001 << l_addr[1:0];
        end
        2'b01: begin
          dwdata = {2{l_wdata[15:0]}};
          we     = 4'b0011 << l_addr[1:0];
        end
        default: begin
          dwdata = l_wdata;
          we     = 4'b1111;
        end
      endcase
      if (!l_wr) we = 4'b0000;
    end
  end

  // Load lane selection and extension
  always_comb begin
    case (l_addr[1:0])
      2'd0:    rd_b = drdata[7:0];
      2'd1:    rd_b = drdata[15:8];
      2'd2:    rd_b = drdata[23:16];
      default: rd_b = drdata[31:24];
    endcase
    rd_h = l_addr[1] ? drdata[31:16] : drdata[15:0];
    case (l_size)
      2'b00:   load_val = {{24{~l_uns & rd_b[7]}}, rd_b};
      2'b01:   load_val = {{16{~l_uns & rd_h[15]}}, rd_h};
      default: load_val = drdata;
    endcase
    if (l_wr || illegal) load_val = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      gnt      <= 1'b0;
      l_wr     <= 1'b0;
      l_uns    <= 1'b0;
      l_size   <= 2'b00;
      l_addr   <= '0;
      l_wdata  <= '0;
      p0_ack   <= 1'b0;
      p0_err   <= 1'b0;
      p0_rdata <= '0;
      p1_ack   <= 1'b0;
      p1_err   <= 1'b0;
      p1_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          state   <= ACCESS;
          gnt     <= sel;
          last    <= sel;
          l_wr    <= sel ? p1_wr    : p0_wr;
          l_size  <= sel ? p1_size  : p0_size;
          l_uns   <= sel ? p1_uns   : p0_uns;
          l_addr  <= sel ? p1_addr  : p0_addr;
          l_wdata <= sel ? p1_wdata : p0_wdata;
        end
        ACCESS: begin
          state    <= RESP;
          p0_ack   <= ~gnt;
          p0_err   <= ~gnt & illegal;
          p0_rdata <= gnt ? '0 : load_val;
          p1_ack   <= gnt;
          p1_err   <= gnt & illegal;
          p1_rdata <= gnt ? load_val : '0;
        end
        RESP: begin
          state    <= IDLE;
          p0_ack   <= 1'b0;
          p0_err   <= 1'b0;
          p0_rdata <= '0;
          p1_ack   <= 1'b0;
          p1_err   <= 1'b0;
          p1_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter. It runs a table of
// directed accesses, then hand-written sequences for round-robin alternation
// and reset during ACCESS, then randomized single-port traffic. All of it is
// checked against a byte-addressed reference model of the memory.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_wr, p0_uns, p0_ack, p0_err;
  logic [1:0]  p0_size;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_req, p1_wr, p1_uns, p1_ack, p1_err;
  logic [1:0]  p1_size;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic [31:0] daddr, dwdata, drdata;
  logic [3:0]  we;
  logic        ce;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_size(p0_size), .p0_uns(p0_uns),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_err(p0_err),
    .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_size(p1_size), .p1_uns(p1_uns),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_err(p1_err),
    .p1_rdata(p1_rdata),
    .daddr(daddr), .dwdata(dwdata), .we(we), .ce(ce), .drdata(drdata)
  );

  // Memory seen by the DUT: 16 words, combinational read
  logic [31:0] mem [16];
  logic [31:0] init_img [16];
  logic        mem_load = 1'b0;
  assign drdata = mem[daddr[5:2]];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_img[i];
    end else if (ce) begin
      for (int b = 0; b < 4; b++)
        if (we[b]) mem[daddr[5:2]][8*b +: 8] <= dwdata[8*b +: 8];
    end
  end

  // Reference memory image, updated byte by byte by the model
  logic [31:0] ref_mem [16];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(int p, logic req, logic wr, logic [1:0] size, logic uns,
                       logic [31:0] addr, logic [31:0] wdata);
    if (p == 0) begin
      p0_req = req; p0_wr = wr; p0_size = size; p0_uns = uns; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = req; p1_wr = wr; p1_size = size; p1_uns = uns; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  we;
    logic        ce;
    logic [31:0] daddr;
    logic [31:0] dwdata;
  } exp_t;

  // Behavioural model: access width in bytes, alignment by modulo, load value
  // by shifting and masking the addressed word.
  function automatic exp_t model(logic wr, logic [1:0] size, logic uns,
                                 logic [31:0] addr, logic [31:0] wdata);
    exp_t e;
    int nb, off;
    longint unsigned mask, v;
    e = '0;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    off = int'(addr % 4);
    if (nb == 0 || (addr % nb) != 0) begin
      e.err = 1'b1;
      return e;
    end
    e.ce = 1'b1;
    e.daddr = addr - off;
    for (int k = 0; k < 4; k++) e.dwdata[8*k +: 8] = wdata[8*(k % nb) +: 8];
    if (wr) begin
      for (int k = off; k < off + nb; k++) e.we[k] = 1'b1;
    end else begin
      mask = (64'd1 << (8*nb)) - 1;
      v = (64'(ref_mem[addr[5:2]]) >> (8*off)) & mask;
      if (!uns && v[8*nb-1]) v = v | ~mask;
      e.rdata = v[31:0];
    end
    return e;
  endfunction

  task automatic commit(logic wr, logic [1:0] size, logic [31:0] addr, logic [31:0] wdata);
    int nb, off;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    off = int'(addr % 4);
    if (wr && nb != 0 && (addr % nb) == 0)
      for (int k = 0; k < nb; k++) ref_mem[addr[5:2]][8*(off+k) +: 8] = wdata[8*k +: 8];
  endtask

  // One access on a single port from IDLE. The requester's fields are
  // scrambled after the grant to show they no longer matter.
  task automatic xact(string tag, int p, logic wr, logic [1:0] size, logic uns,
                      logic [31:0] addr, logic [31:0] wdata, logic exp_err,
                      logic [31:0] exp_rdata, logic [3:0] exp_we, logic exp_ce);
    exp_t m;
    int lat;
    logic got, err, oth;
    logic [31:0] rd;
    m = model(wr, size, uns, addr, wdata);
    drive(p, 1'b1, wr, size, uns, addr, wdata);
    lat = 0; got = 1'b0; err = 1'b0; oth = 1'b0; rd = '0;
    for (int i = 1; i <= 8 && !got; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check({tag, " ce"}, 32'(ce), 32'(exp_ce));
        check({tag, " we"}, 32'(we), 32'(exp_we));
        if (exp_ce) begin
          check({tag, " daddr"}, daddr, m.daddr);
          check({tag, " dwdata"}, dwdata, m.dwdata);
        end
        drive(p, 1'b1, ~wr, size + 2'd1, ~uns, addr ^ 32'h1c, ~wdata);
      end
      if ((p == 0) ? p0_ack : p1_ack) begin
        got = 1'b1;
        lat = i;
        err = (p == 0) ? p0_err : p1_err;
        rd  = (p == 0) ? p0_rdata : p1_rdata;
        oth = (p == 0) ? (p1_ack | p1_err | (|p1_rdata)) : (p0_ack | p0_err | (|p0_rdata));
      end
    end
    drive(p, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    check({tag, " latency"}, 32'(lat), 32'd2);
    check({tag, " err"}, 32'(err), 32'(exp_err));
    check({tag, " rdata"}, rd, exp_rdata);
    check({tag, " other port quiet"}, 32'(oth), 32'd0);
    commit(wr, size, addr, wdata);
    @(negedge clk);
  endtask

  typedef struct {
    int          p;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  we;
    logic        ce;
  } vec_t;

  vec_t tbl [12];
  int   ack_port [$];
  int   ack_cyc  [$];

  initial begin
    int exp_c [4];
    int exp_p [4];
    int first_p, first_c;
    exp_t m;
    int p;
    logic wr, uns;
    logic [1:0] size;
    logic [31:0] addr, wdata;

    // {port, wr, size, uns, addr, wdata, err, rdata, we, ce}
    tbl[0]  = '{1, 1'b0, 2'b01, 1'b0, 32'h06, 32'h0,         1'b0, 32'hFFFF80FF, 4'b0000, 1'b1};
    tbl[1]  = '{1, 1'b0, 2'b01, 1'b1, 32'h06, 32'h0,         1'b0, 32'h000080FF, 4'b0000, 1'b1};
    tbl[2]  = '{0, 1'b1, 2'b00, 1'b0, 32'h05, 32'hAB,        1'b0, 32'h0,        4'b0010, 1'b1};
    tbl[3]  = '{0, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0,         1'b0, 32'h80FFAB34, 4'b0000, 1'b1};
    tbl[4]  = '{0, 1'b0, 2'b00, 1'b0, 32'h05, 32'h0,         1'b0, 32'hFFFFFFAB, 4'b0000, 1'b1};
    tbl[5]  = '{1, 1'b1, 2'b10, 1'b0, 32'h02, 32'hCAFEF00D,  1'b1, 32'h0,        4'b0000, 1'b0};
    tbl[6]  = '{1, 1'b1, 2'b11, 1'b0, 32'h00, 32'hCAFEF00D,  1'b1, 32'h0,        4'b0000, 1'b0};
    tbl[7]  = '{0, 1'b0, 2'b01, 1'b0, 32'h03, 32'h0,         1'b1, 32'h0,        4'b0000, 1'b0};
    tbl[8]  = '{1, 1'b1, 2'b01, 1'b0, 32'h0A, 32'h12345678,  1'b0, 32'h0,        4'b1100, 1'b1};
    tbl[9]  = '{1, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0,         1'b0, 32'h56780000, 4'b0000, 1'b1};
    tbl[10] = '{0, 1'b0, 2'b00, 1'b1, 32'h0B, 32'h0,         1'b0, 32'h00000056, 4'b0000, 1'b1};
    tbl[11] = '{0, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0,         1'b0, 32'h80FFAB34, 4'b0000, 1'b1};

    for (int i = 0; i < 16; i++) init_img[i] = $urandom;
    init_img[0] = 32'h00000000;
    init_img[1] = 32'h80FF1234;
    init_img[2] = 32'h00000000;
    init_img[4] = 32'h11111111;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_img[i];

    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    mem_load = 1'b1;
    #2;
    check("reset p0_ack", 32'(p0_ack), 32'd0);
    check("reset p1_ack", 32'(p1_ack), 32'd0);
    check("reset err", 32'({p0_err, p1_err}), 32'd0);
    check("reset rdata", p0_rdata | p1_rdata, 32'd0);
    check("reset ce/we", 32'({ce, we}), 32'd0);
    check("reset daddr", daddr, 32'd0);
    check("reset dwdata", dwdata, 32'd0);
    @(negedge clk);
    mem_load = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      xact($sformatf("tbl%0d", i), tbl[i].p, tbl[i].wr, tbl[i].size, tbl[i].uns,
           tbl[i].addr, tbl[i].wdata, tbl[i].err, tbl[i].rdata, tbl[i].we, tbl[i].ce);

    // Round-robin from reset with both requests held continuously
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
    drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (p0_ack) begin ack_port.push_back(0); ack_cyc.push_back(c); end
      if (p1_ack) begin ack_port.push_back(1); ack_cyc.push_back(c); end
    end
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    exp_p = '{0, 1, 0, 1};
    exp_c = '{2, 5, 8, 11};
    check("rr ack count", 32'(ack_port.size()), 32'd4);
    for (int i = 0; i < 4 && i < ack_port.size(); i++) begin
      check($sformatf("rr ack%0d port", i), 32'(ack_port[i]), 32'(exp_p[i]));
      check($sformatf("rr ack%0d cycle", i), 32'(ack_cyc[i]), 32'(exp_c[i]));
    end

    // Reset in the middle of a word store to 0x10
    drive(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    check("rst store ce", 32'(ce), 32'd1);
    check("rst store we", 32'(we), 32'hF);
    #2 rst_n = 1'b0;
    #1;
    check("rst we drop", 32'(we), 32'd0);
    check("rst ce drop", 32'(ce), 32'd0);
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("rst no ack", 32'(p0_ack | p1_ack), 32'd0);
    @(negedge clk);
    check("rst mem 0x10", mem[4], ref_mem[4]);
    rst_n = 1'b1;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
    drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
    first_p = -1; first_c = 0;
    for (int c = 1; c <= 6 && first_p < 0; c++) begin
      @(negedge clk);
      if (p0_ack) begin first_p = 0; first_c = c; end
      else if (p1_ack) begin first_p = 1; first_c = c; end
    end
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    check("post-rst tie winner", 32'(first_p), 32'd0);
    check("post-rst ack cycle", 32'(first_c), 32'd2);
    repeat (3) @(negedge clk);

    // Randomized single-port traffic against the model
    for (int n = 0; n < 150; n++) begin
      p     = int'($urandom_range(0, 1));
      wr    = 1'($urandom_range(0, 1));
      size  = 2'($urandom_range(0, 3));
      uns   = 1'($urandom_range(0, 1));
      addr  = 32'($urandom_range(0, 63));
      wdata = $urandom;
      m = model(wr, size, uns, addr, wdata);
      xact($sformatf("rnd%0d", n), p, wr, size, uns, addr, wdata, m.err, m.rdata, m.we, m.ce);
    end

    for (int i = 0; i < 16; i++)
      check($sformatf("final mem[%0d]", i), mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
